// File: rtl/lms_sequencer.sv
// lms_sequencer: flush/train/track sequencing and convergence detection for an external LMS filter
module lms_sequencer #(
  parameter int DATA_WIDTH   = 12,
  parameter int FILTER_ORDER = 5,
  parameter int TRAIN_LEN    = 256,
  parameter int ERR_THRESH   = 64,
  parameter int CONV_RUN     = 16
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic                  stop_in,
  input  logic                  sample_valid_in,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [DATA_WIDTH-1:0] ref_in,
  output logic                  sample_ready_out,
  input  logic                  err_valid_in,
  input  logic [DATA_WIDTH-1:0] err_in,
  output logic [DATA_WIDTH-1:0] lms_x_out,
  output logic [DATA_WIDTH-1:0] lms_ref_out,
  output logic                  lms_en_out,
  output logic                  adapt_en_out,
  output logic                  lms_resetn_out,
  output logic                  converged_out,
  output logic                  busy_out,
  output logic [1:0]            state_out
);
  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, TRAIN = 2'd2, TRACK = 2'd3} state_t;
  localparam int CW = $clog2(TRAIN_LEN + FILTER_ORDER + 1);
  localparam int RW = $clog2(CONV_RUN + 1);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MAX_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [RW-1:0] RUN_MAX = RW'(CONV_RUN);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] run_q, run_d;
  logic conv_q, conv_d, en_q, en_d, adapt_q, adapt_d;
  logic [DATA_WIDTH-1:0] x_q, x_d, ref_q, ref_d, mag;
  logic xfer, flush_stb, in_th;
  // TRAIN and TRACK share state bit 1; stop blocks acceptance in the cycle it is seen
  assign sample_ready_out = state_q[1] && !stop_in;
  assign xfer = sample_valid_in && sample_ready_out;
  assign flush_stb = (state_q == FLUSH) && !stop_in;
  // most-negative error has no positive twin, so it saturates to the largest magnitude
  assign mag = (err_in == MIN_NEG) ? MAX_POS : err_in[DATA_WIDTH-1] ? -err_in : err_in;
  assign in_th = 32'(mag) <= 32'(ERR_THRESH);
  assign lms_x_out = x_q;
  assign lms_ref_out = ref_q;
  assign lms_en_out = en_q;
  assign adapt_en_out = adapt_q;
  assign lms_resetn_out = state_q != IDLE;
  assign converged_out = conv_q;
  assign busy_out = state_q != IDLE;
  assign state_out = state_q;
  // next state and the flush/train counter
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (start_in) begin
        state_d = FLUSH;
        cnt_d = '0;
      end
    end else if (stop_in) begin
      state_d = IDLE;
    end else if (state_q == FLUSH) begin
      cnt_d = (cnt_q == CW'(FILTER_ORDER - 1)) ? '0 : cnt_q + 1'b1;
      state_d = (cnt_q == CW'(FILTER_ORDER - 1)) ? TRAIN : FLUSH;
    end else if (state_q == TRAIN && xfer) begin
      cnt_d = (cnt_q == CW'(TRAIN_LEN - 1)) ? '0 : cnt_q + 1'b1;
      state_d = (cnt_q == CW'(TRAIN_LEN - 1)) ? TRACK : TRAIN;
    end
  end
  // convergence run counter and the strobe/data pipeline stage to the filter
  always_comb begin
    run_d = run_q;
    if (state_q == IDLE && start_in)
      run_d = '0;
    else if (err_valid_in && state_q[1])
      run_d = !in_th ? '0 : (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    conv_d = run_d == RUN_MAX;
    en_d = flush_stb || xfer;
    x_d = flush_stb ? '0 : xfer ? x_in : x_q;
    ref_d = flush_stb ? '0 : xfer ? ref_in : ref_q;
    adapt_d = xfer && (state_q == TRAIN || !conv_d);
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      cnt_q <= '0;
      run_q <= '0;
      conv_q <= 1'b0;
      en_q <= 1'b0;
      adapt_q <= 1'b0;
      x_q <= '0;
      ref_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      conv_q <= conv_d;
      en_q <= en_d;
      adapt_q <= adapt_d;
      x_q <= x_d;
      ref_q <= ref_d;
    end
  end
endmodule

// File: tb/tb_lms_sequencer.sv
// tb_lms_sequencer: directed self-checking bench for lms_sequencer
module tb_lms_sequencer;
  logic clk_in = 1'b0, reset_in, start_in, stop_in, sample_valid_in, err_valid_in;
  logic [11:0] x_in, ref_in, err_in, lms_x_out, lms_ref_out;
  logic sample_ready_out, lms_en_out, adapt_en_out, lms_resetn_out, converged_out, busy_out;
  logic [1:0] state_out;
  int n_vec = 0, n_bad = 0;
  lms_sequencer dut (
    .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in), .stop_in(stop_in),
    .sample_valid_in(sample_valid_in), .x_in(x_in), .ref_in(ref_in),
    .sample_ready_out(sample_ready_out), .err_valid_in(err_valid_in), .err_in(err_in),
    .lms_x_out(lms_x_out), .lms_ref_out(lms_ref_out), .lms_en_out(lms_en_out),
    .adapt_en_out(adapt_en_out), .lms_resetn_out(lms_resetn_out),
    .converged_out(converged_out), .busy_out(busy_out), .state_out(state_out)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask
  initial begin
    reset_in = 1'b1; start_in = 1'b0; stop_in = 1'b0; sample_valid_in = 1'b0;
    err_valid_in = 1'b0; x_in = '0; ref_in = '0; err_in = '0;
    #3;
    chk("rst_state", 32'(state_out), 0);
    chk("rst_en", 32'(lms_en_out), 0);
    chk("rst_resetn", 32'(lms_resetn_out), 0);
    chk("rst_ready", 32'(sample_ready_out), 0);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_x", 32'(lms_x_out), 0);
    chk("rst_conv", 32'(converged_out), 0);
    @(negedge clk_in);
    reset_in = 1'b0;
    tick;
    chk("idle_state", 32'(state_out), 0);
    sample_valid_in = 1'b1; x_in = 12'h123; ref_in = 12'h0AB;
    start_in = 1'b1;
    tick;
    start_in = 1'b0;
    chk("flush_state", 32'(state_out), 1);
    chk("flush_en0", 32'(lms_en_out), 0);
    chk("flush_busy", 32'(busy_out), 1);
    chk("flush_resetn", 32'(lms_resetn_out), 1);
    chk("flush_ready", 32'(sample_ready_out), 0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("flush_stb_en", 32'(lms_en_out), 1);
      chk("flush_stb_x", 32'(lms_x_out), 0);
      chk("flush_stb_ref", 32'(lms_ref_out), 0);
      chk("flush_stb_adapt", 32'(adapt_en_out), 0);
    end
    chk("train_state", 32'(state_out), 2);
    chk("train_ready", 32'(sample_ready_out), 1);
    tick;
    chk("train_en", 32'(lms_en_out), 1);
    chk("train_x", 32'(lms_x_out), 32'h123);
    chk("train_ref", 32'(lms_ref_out), 32'h0AB);
    chk("train_adapt", 32'(adapt_en_out), 1);
    repeat (254) tick;
    chk("train255_state", 32'(state_out), 2);
    tick;
    chk("track_state", 32'(state_out), 3);
    chk("last_train_en", 32'(lms_en_out), 1);
    chk("last_train_adapt", 32'(adapt_en_out), 1);
    sample_valid_in = 1'b0;
    tick;
    chk("idle_strobe_en", 32'(lms_en_out), 0);
    chk("hold_x", 32'(lms_x_out), 32'h123);
    err_valid_in = 1'b1; err_in = 12'd10;
    repeat (15) tick;
    chk("conv_15", 32'(converged_out), 0);
    tick;
    chk("conv_16", 32'(converged_out), 1);
    err_valid_in = 1'b0; sample_valid_in = 1'b1; x_in = 12'h055;
    tick;
    sample_valid_in = 1'b0;
    chk("track_conv_en", 32'(lms_en_out), 1);
    chk("track_conv_x", 32'(lms_x_out), 32'h055);
    chk("track_conv_adapt", 32'(adapt_en_out), 0);
    err_valid_in = 1'b1; err_in = 12'hF9C;
    tick;
    chk("conv_drop_m100", 32'(converged_out), 0);
    err_valid_in = 1'b0; sample_valid_in = 1'b1; x_in = 12'h066;
    tick;
    sample_valid_in = 1'b0;
    chk("track_unconv_adapt", 32'(adapt_en_out), 1);
    err_valid_in = 1'b1; err_in = 12'd64;
    repeat (15) tick;
    err_in = 12'd65;
    tick;
    chk("thresh_65_clears", 32'(converged_out), 0);
    err_in = 12'hFC0;
    repeat (15) tick;
    chk("neg64_15", 32'(converged_out), 0);
    tick;
    chk("neg64_16", 32'(converged_out), 1);
    err_in = 12'h800;
    tick;
    chk("most_neg_clears", 32'(converged_out), 0);
    err_in = 12'd0;
    repeat (16) tick;
    chk("reconv", 32'(converged_out), 1);
    err_valid_in = 1'b0;
    start_in = 1'b1;
    tick;
    start_in = 1'b0;
    chk("start_ignored", 32'(state_out), 3);
    stop_in = 1'b1; sample_valid_in = 1'b1; x_in = 12'h077;
    #1;
    chk("stop_ready", 32'(sample_ready_out), 0);
    tick;
    stop_in = 1'b0; sample_valid_in = 1'b0;
    chk("stop_track_state", 32'(state_out), 0);
    chk("stop_track_en", 32'(lms_en_out), 0);
    chk("stop_track_x", 32'(lms_x_out), 32'h066);
    start_in = 1'b1;
    tick;
    start_in = 1'b0;
    chk("restart_conv_clr", 32'(converged_out), 0);
    repeat (5) tick;
    chk("retrain_state", 32'(state_out), 2);
    sample_valid_in = 1'b1; x_in = 12'h0AA;
    tick;
    chk("retrain_x", 32'(lms_x_out), 32'h0AA);
    stop_in = 1'b1; x_in = 12'h0BB;
    tick;
    stop_in = 1'b0; sample_valid_in = 1'b0;
    chk("stop_train_en", 32'(lms_en_out), 0);
    chk("stop_train_state", 32'(state_out), 0);
    chk("stop_train_resetn", 32'(lms_resetn_out), 0);
    chk("stop_train_x", 32'(lms_x_out), 32'h0AA);
    start_in = 1'b1;
    tick;
    start_in = 1'b0;
    tick;
    chk("midflush_state", 32'(state_out), 1);
    chk("midflush_en", 32'(lms_en_out), 1);
    #2 reset_in = 1'b1;
    #1;
    chk("async_state", 32'(state_out), 0);
    chk("async_en", 32'(lms_en_out), 0);
    chk("async_resetn", 32'(lms_resetn_out), 0);
    chk("async_busy", 32'(busy_out), 0);
    chk("async_ready", 32'(sample_ready_out), 0);
    @(negedge clk_in);
    reset_in = 1'b0;
    tick;
    tick;
    chk("post_rst_state", 32'(state_out), 0);
    chk("post_rst_en", 32'(lms_en_out), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
